// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: extender selects, FSM
// states, opcode/funct values, ALU operation codes and the decoded instruction class.
package multi_cycle_ctrl_pkg;

   localparam logic [1:0] EXT_UNSIGNED = 2'b00;
   localparam logic [1:0] EXT_SIGNED   = 2'b01;
   localparam logic [1:0] EXT_POS_H    = 2'b10;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEM_ADDR = 4'd2;
   localparam logic [3:0] S_MEM_RD   = 4'd3;
   localparam logic [3:0] S_MEM_WB   = 4'd4;
   localparam logic [3:0] S_MEM_WR   = 4'd5;
   localparam logic [3:0] S_EXE_R    = 4'd6;
   localparam logic [3:0] S_EXE_SH   = 4'd7;
   localparam logic [3:0] S_WB_R     = 4'd8;
   localparam logic [3:0] S_EXE_I    = 4'd9;
   localparam logic [3:0] S_WB_I     = 4'd10;
   localparam logic [3:0] S_BRANCH   = 4'd11;
   localparam logic [3:0] S_JUMP     = 4'd12;
   localparam logic [3:0] S_JAL      = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   // ALU_FUNCT hands operation selection to the ALU control, which decodes funct.
   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_FUNCT = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_LUI   = 3'd4;

   typedef enum logic [3:0] {
      K_R, K_SH, K_LW, K_SW, K_ADDIU, K_ORI, K_LUI, K_BEQ, K_J, K_JAL, K_ILL
   } op_kind_e;

   function automatic logic [1:0] imm_ext(input op_kind_e kind);
      case (kind)
         K_ORI:   return EXT_UNSIGNED;
         K_LUI:   return EXT_POS_H;
         default: return EXT_SIGNED;
      endcase
   endfunction

   function automatic logic [2:0] imm_aluop(input op_kind_e kind);
      case (kind)
         K_ORI:   return ALU_OR;
         K_LUI:   return ALU_LUI;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class,
// flagging any encoding the controller does not implement.
module ctrl_decode
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output op_kind_e   kind,
   output logic       illegal
);

   always_comb begin
      kind = K_ILL;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_SLL, FN_SRL:                           kind = K_SH;
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT:  kind = K_R;
               default:                                  kind = K_ILL;
            endcase
         end
         OP_LW:    kind = K_LW;
         OP_SW:    kind = K_SW;
         OP_ADDIU: kind = K_ADDIU;
         OP_ORI:   kind = K_ORI;
         OP_LUI:   kind = K_LUI;
         OP_BEQ:   kind = K_BEQ;
         OP_J:     kind = K_J;
         OP_JAL:   kind = K_JAL;
         default:  kind = K_ILL;
      endcase
   end

   assign illegal = (kind == K_ILL);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM. The instruction class is captured in DECODE so
// later states can select extender mode and ALU operation without re-decoding.
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemToReg,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] EXTSel,
   output logic [1:0] EXT5Sel,
   output logic       illegal,
   output logic [3:0] state
);

   logic [3:0] state_q, state_d;
   op_kind_e   kind_q;
   op_kind_e   dec_kind;
   logic       dec_illegal;

   ctrl_decode u_decode (
      .opcode  (opcode),
      .funct   (funct),
      .kind    (dec_kind),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         kind_q  <= K_ILL;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) kind_q <= dec_kind;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (dec_kind)
               K_R:                    state_d = S_EXE_R;
               K_SH:                   state_d = S_EXE_SH;
               K_LW, K_SW:             state_d = S_MEM_ADDR;
               K_ADDIU, K_ORI, K_LUI:  state_d = S_EXE_I;
               K_BEQ:                  state_d = S_BRANCH;
               K_J:                    state_d = S_JUMP;
               K_JAL:                  state_d = S_JAL;
               default:                state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR: state_d = (kind_q == K_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_EXE_R, S_EXE_SH: state_d = S_WB_R;
         S_EXE_I:    state_d = S_WB_I;
         default:    state_d = S_FETCH;
      endcase
   end

   // Defaults double as the reset values: every output is forced quiet while rst is high.
   always_comb begin
      PCWrite  = 1'b0;
      PCSrc    = 2'd0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 2'd0;
      MemToReg = 2'd0;
      ALUSrcA  = 2'd0;
      ALUSrcB  = 2'd0;
      ALUOp    = ALU_ADD;
      EXTSel   = EXT_UNSIGNED;
      EXT5Sel  = EXT_UNSIGNED;
      illegal  = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
               ALUSrcB = 2'd1;
            end
            S_DECODE: begin
               EXTSel  = EXT_SIGNED;
               ALUSrcB = 2'd2;
               illegal = dec_illegal;
            end
            S_MEM_ADDR: begin
               ALUSrcA = 2'd1;
               ALUSrcB = 2'd2;
               EXTSel  = EXT_SIGNED;
            end
            S_MEM_RD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEM_WB: begin
               RegWrite = 1'b1;
               MemToReg = 2'd1;
            end
            S_MEM_WR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_EXE_R: begin
               ALUSrcA = 2'd1;
               ALUOp   = ALU_FUNCT;
            end
            S_EXE_SH: begin
               ALUSrcA = 2'd2;
               ALUSrcB = 2'd3;
               ALUOp   = ALU_FUNCT;
            end
            S_WB_R: begin
               RegWrite = 1'b1;
               RegDst   = 2'd1;
            end
            S_EXE_I: begin
               ALUSrcA = 2'd1;
               ALUSrcB = 2'd2;
               EXTSel  = imm_ext(kind_q);
               ALUOp   = imm_aluop(kind_q);
            end
            S_WB_I: begin
               RegWrite = 1'b1;
               EXTSel   = imm_ext(kind_q);
            end
            S_BRANCH: begin
               ALUSrcA = 2'd1;
               ALUOp   = ALU_SUB;
               PCSrc   = 2'd1;
               PCWrite = zero;
            end
            S_JUMP: begin
               PCSrc   = 2'd2;
               PCWrite = 1'b1;
            end
            S_JAL: begin
               PCSrc    = 2'd2;
               PCWrite  = 1'b1;
               RegWrite = 1'b1;
               RegDst   = 2'd2;
               MemToReg = 2'd2;
            end
            default: ;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench: an instruction-level model expands each instruction into the
// per-cycle control vector it should produce; a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;
   import multi_cycle_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0, funct = '0;
   logic       zero = 1'b0, mem_ready = 1'b0;
   logic       PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, illegal;
   logic [1:0] PCSrc, RegDst, MemToReg, ALUSrcA, ALUSrcB, EXTSel, EXT5Sel;
   logic [2:0] ALUOp;
   logic [3:0] state;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multi_cycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .EXTSel(EXTSel), .EXT5Sel(EXT5Sel), .illegal(illegal), .state(state)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic [1:0] pcsrc;
      logic       irw, mrd, mwr, iord, rw;
      logic [1:0] rdst, m2r, asa, asb;
      logic [2:0] aop;
      logic [1:0] ext, ext5;
      logic       ill;
   } exp_t;

   typedef struct {
      exp_t       e;
      logic       mr;
      logic       z;
      logic [5:0] op;
      logic [5:0] fn;
   } step_t;

   step_t prog[$];
   exp_t  exp_q[$];
   logic [5:0] g_op, g_fn;

   function automatic exp_t blank(input logic [3:0] st);
      exp_t e = '0;
      e.st  = st;
      e.aop = ALU_ADD;
      e.ext = EXT_UNSIGNED;
      return e;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic add(input exp_t e, input logic mr, input logic z);
      step_t s;
      s.e = e; s.mr = mr; s.z = z; s.op = g_op; s.fn = g_fn;
      prog.push_back(s);
   endtask

   // Expected cycles of a memory-access state: `w` stalled cycles, then the completing one.
   task automatic mem_phase(input exp_t e, input int w);
      for (int i = 0; i < w; i++) add(e, 1'b0, rb());
      add(e, 1'b1, rb());
   endtask

   // memw < 0 picks a random memory wait count.
   task automatic gen(input logic [5:0] op, input logic [5:0] fn, input int memw);
      exp_t e;
      int   w;
      logic z;
      g_op = op; g_fn = fn;
      w = $urandom_range(0, 2);
      e = blank(S_FETCH); e.mrd = 1'b1; e.asb = 2'd1;
      for (int i = 0; i < w; i++) add(e, 1'b0, rb());
      e.irw = 1'b1; e.pcw = 1'b1;
      add(e, 1'b1, rb());
      e = blank(S_DECODE); e.ext = EXT_SIGNED; e.asb = 2'd2;
      w = (memw < 0) ? int'($urandom_range(0, 3)) : memw;
      case (op)
         6'b000000: begin
            if (fn == 6'b000000 || fn == 6'b000010) begin
               add(e, rb(), rb());
               e = blank(S_EXE_SH); e.asa = 2'd2; e.asb = 2'd3; e.aop = ALU_FUNCT;
               e.ext5 = EXT_UNSIGNED;
               add(e, rb(), rb());
               e = blank(S_WB_R); e.rw = 1'b1; e.rdst = 2'd1; add(e, rb(), rb());
            end else if (fn inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010}) begin
               add(e, rb(), rb());
               e = blank(S_EXE_R); e.asa = 2'd1; e.aop = ALU_FUNCT; add(e, rb(), rb());
               e = blank(S_WB_R); e.rw = 1'b1; e.rdst = 2'd1; add(e, rb(), rb());
            end else begin
               e.ill = 1'b1; add(e, rb(), rb());
            end
         end
         6'b100011, 6'b101011: begin
            add(e, rb(), rb());
            e = blank(S_MEM_ADDR); e.asa = 2'd1; e.asb = 2'd2; e.ext = EXT_SIGNED;
            add(e, rb(), rb());
            if (op == 6'b100011) begin
               e = blank(S_MEM_RD); e.mrd = 1'b1; e.iord = 1'b1; mem_phase(e, w);
               e = blank(S_MEM_WB); e.rw = 1'b1; e.m2r = 2'd1; add(e, rb(), rb());
            end else begin
               e = blank(S_MEM_WR); e.mwr = 1'b1; e.iord = 1'b1; mem_phase(e, w);
            end
         end
         6'b001001, 6'b001101, 6'b001111: begin
            add(e, rb(), rb());
            e = blank(S_EXE_I); e.asa = 2'd1; e.asb = 2'd2;
            if (op == 6'b001001) begin e.ext = EXT_SIGNED;   e.aop = ALU_ADD; end
            if (op == 6'b001101) begin e.ext = EXT_UNSIGNED; e.aop = ALU_OR;  end
            if (op == 6'b001111) begin e.ext = EXT_POS_H;    e.aop = ALU_LUI; end
            add(e, rb(), rb());
            e.st = S_WB_I; e.asa = 2'd0; e.asb = 2'd0; e.aop = ALU_ADD; e.rw = 1'b1;
            add(e, rb(), rb());
         end
         6'b000100: begin
            add(e, rb(), rb());
            z = rb();
            e = blank(S_BRANCH); e.asa = 2'd1; e.aop = ALU_SUB; e.pcsrc = 2'd1; e.pcw = z;
            add(e, rb(), z);
         end
         6'b000010: begin
            add(e, rb(), rb());
            e = blank(S_JUMP); e.pcsrc = 2'd2; e.pcw = 1'b1; add(e, rb(), rb());
         end
         6'b000011: begin
            add(e, rb(), rb());
            e = blank(S_JAL); e.pcsrc = 2'd2; e.pcw = 1'b1; e.rw = 1'b1;
            e.rdst = 2'd2; e.m2r = 2'd2;
            add(e, rb(), rb());
         end
         default: begin
            e.ill = 1'b1; add(e, rb(), rb());
         end
      endcase
   endtask

   // Enter at posedge+1; each step drives one cycle and leaves the bench at the next posedge+1.
   task automatic run_prog();
      step_t s;
      while (prog.size() > 0) begin
         s = prog.pop_front();
         opcode = s.op; funct = s.fn; mem_ready = s.mr; zero = s.z;
         exp_q.push_back(s.e);
         @(posedge clk); #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.st = state; a.pcw = PCWrite; a.pcsrc = PCSrc; a.irw = IRWrite; a.mrd = MemRead;
         a.mwr = MemWrite; a.iord = IorD; a.rw = RegWrite; a.rdst = RegDst; a.m2r = MemToReg;
         a.asa = ALUSrcA; a.asb = ALUSrcB; a.aop = ALUOp; a.ext = EXTSel; a.ext5 = EXT5Sel;
         a.ill = illegal;
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL ctrl cyc%0d op=%b fn=%b: got st=%0d vec=%h, required st=%0d vec=%h",
                     cyc, opcode, funct, a.st, a, e.st, e);
         end else begin
            $display("[TB] cyc%0d st=%0d vec=%h ok", cyc, a.st, a);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   localparam int NPOOL = 20;
   logic [11:0] pool [NPOOL] = '{
      {6'b000000, 6'b100001}, {6'b000000, 6'b100011}, {6'b000000, 6'b100100},
      {6'b000000, 6'b100101}, {6'b000000, 6'b101010}, {6'b000000, 6'b000000},
      {6'b000000, 6'b000010}, {6'b100011, 6'b010101}, {6'b101011, 6'b000000},
      {6'b001001, 6'b111000}, {6'b001101, 6'b000001}, {6'b001111, 6'b000000},
      {6'b000100, 6'b000000}, {6'b000010, 6'b000000}, {6'b000011, 6'b000000},
      {6'b111111, 6'b000000}, {6'b000000, 6'b001000}, {6'b000101, 6'b000000},
      {6'b100000, 6'b100001}, {6'b000000, 6'b111111}
   };

   initial begin
      logic [11:0] pick;
      mem_ready = 1'b1;
      #3;
      chk("rst_state",    32'(state),    32'(S_FETCH));
      chk("rst_memread",  32'(MemRead),  0);
      chk("rst_wen",      32'({PCWrite, IRWrite, RegWrite, MemWrite}), 0);
      chk("rst_selects",  32'({PCSrc, RegDst, MemToReg, ALUSrcA, ALUSrcB, IorD}), 0);
      chk("rst_extsel",   32'(EXTSel),   32'(EXT_UNSIGNED));
      chk("rst_illegal",  32'(illegal),  0);
      @(posedge clk); #1;
      rst = 1'b0;

      gen(6'b001001, 6'b000000, 0);   // addiu
      gen(6'b001111, 6'b000000, 0);   // lui
      gen(6'b001101, 6'b000000, 0);   // ori
      gen(6'b100011, 6'b000000, 3);   // lw with three stall cycles
      g_op = 6'b000100;
      gen(6'b000100, 6'b000000, 0);   // beq, random zero
      gen(6'b111111, 6'b000000, 0);   // illegal
      gen(6'b101011, 6'b000000, 2);   // sw
      run_prog();

      for (int i = 0; i < 150; i++) begin
         pick = pool[$urandom_range(0, NPOOL - 1)];
         gen(pick[11:6], pick[5:0], -1);
      end
      run_prog();

      // sw interrupted by an asynchronous reset while stalled in MEM_WR
      g_op = 6'b101011; g_fn = 6'b000000;
      gen(6'b101011, 6'b000000, 0);
      void'(prog.pop_back());
      run_prog();
      opcode = 6'b101011; mem_ready = 1'b0;
      exp_q.push_back(prog.size() == 0 ? '0 : '0);
      void'(exp_q.pop_back());
      #1;
      chk("mw_before_rst", 32'({state, MemWrite}), 32'({S_MEM_WR, 1'b1}));
      rst = 1'b1;
      #1;
      chk("async_rst_state",    32'(state),    32'(S_FETCH));
      chk("async_rst_memwrite", 32'(MemWrite), 0);
      chk("async_rst_iord",     32'({IorD, MemRead}), 0);
      @(posedge clk); #1;
      chk("held_rst_state", 32'(state), 32'(S_FETCH));
      rst = 1'b0;
      gen(6'b001001, 6'b000000, 0);
      run_prog();

      @(negedge clk); #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
